// File: rtl/wt_store_wbuffer.sv
// Write-through store buffer: holds word-granular stores until they are issued
// to the data-cache memory port, and frees each entry on its write acknowledge.
// Optional store merging into pending cacheable entries: WT_WBUFFER_MERGE_EN.
//
// Handshakes: st_* and mem_req/mem_gnt both transfer on the cycle where valid
// (req) and ready (gnt) are high together. The offering side holds its payload
// until then. mem_ack_i is a single-cycle pulse with no back-pressure.
module wt_store_wbuffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PLEN  = 34,
   parameter int unsigned TID_W = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 st_valid_i,
   output logic                 st_ready_o,
   input  logic [PLEN-1:0]      st_paddr_i,
   input  logic [XLEN-1:0]      st_data_i,
   input  logic [XLEN/8-1:0]    st_be_i,
   input  logic                 st_nc_i,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic [PLEN-1:0]      mem_addr_o,
   output logic [XLEN-1:0]      mem_data_o,
   output logic [XLEN/8-1:0]    mem_be_o,
   output logic                 mem_nc_o,
   output logic [TID_W-1:0]     mem_tid_o,
   input  logic                 mem_ack_i,
   input  logic [TID_W-1:0]     mem_ack_tid_i,
   output logic                 empty_o,
   output logic [2*DEPTH-1:0]   dbg_state_o
);

   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      E_FREE = 2'd0,
      E_PEND = 2'd1,
      E_SENT = 2'd2
   } ent_state_e;

   ent_state_e        state_q [DEPTH];
   ent_state_e        state_d [DEPTH];
   logic [PLEN-1:0]   addr_q  [DEPTH];
   logic [PLEN-1:0]   addr_d  [DEPTH];
   logic [XLEN-1:0]   data_q  [DEPTH];
   logic [XLEN-1:0]   data_d  [DEPTH];
   logic [BE_W-1:0]   be_q    [DEPTH];
   logic [BE_W-1:0]   be_d    [DEPTH];
   logic              nc_q    [DEPTH];
   logic              nc_d    [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  iss_ptr_q, iss_ptr_d;
   logic              empty_q, empty_d;
   // Set once something has been issued since reset; acks before that may be
   // stragglers from before the reset and are legitimately ignored.
   logic              arm_q, arm_d;

   logic [PLEN-1:0]   st_word;
   logic              wr_free;
   logic              grant;
   logic              st_fire;
   logic              merge_hit;
   logic              merge_safe;
   logic [PTR_W-1:0]  merge_idx;
   logic              ack_hits_sent;
   logic              unused_addr_lsb;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign st_word         = {st_paddr_i[PLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign unused_addr_lsb = ^st_paddr_i[OFF_W-1:0];
   assign wr_free         = (state_q[wr_ptr_q] == E_FREE);
   assign mem_req_o       = (state_q[iss_ptr_q] == E_PEND);
   assign grant           = mem_req_o && mem_gnt_i;
   // The head entry may be granted this cycle, so only non-head matches can
   // guarantee a merge; this keeps ready independent of mem_gnt_i.
   assign st_ready_o      = wr_free || merge_safe;
   assign st_fire         = st_valid_i && st_ready_o;

`ifdef WT_WBUFFER_MERGE_EN
   // Find a pending cacheable entry holding the same word as the incoming store.
   always_comb begin
      merge_hit  = 1'b0;
      merge_safe = 1'b0;
      merge_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (state_q[i] == E_PEND && !nc_q[i] && !st_nc_i && addr_q[i] == st_word) begin
            if (PTR_W'(i) != iss_ptr_q) merge_safe = 1'b1;
            if (!(grant && PTR_W'(i) == iss_ptr_q)) begin
               merge_hit = 1'b1;
               merge_idx = PTR_W'(i);
            end
         end
      end
   end
`else
   assign merge_hit  = 1'b0;
   assign merge_safe = 1'b0;
   assign merge_idx  = '0;
`endif

   // Detect whether the current ack targets an entry that is awaiting one.
   always_comb begin
      ack_hits_sent = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_ack_tid_i == TID_W'(i) && state_q[i] == E_SENT) ack_hits_sent = 1'b1;
      end
   end

   // Next-state for entries and pointers: issue, ack, then accept.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      be_d      = be_q;
      nc_d      = nc_q;
      wr_ptr_d  = wr_ptr_q;
      iss_ptr_d = iss_ptr_q;
      arm_d     = arm_q;
      empty_d   = 1'b1;

      if (grant) begin
         state_d[iss_ptr_q] = E_SENT;
         iss_ptr_d          = ptr_inc(iss_ptr_q);
         arm_d              = 1'b1;
      end

      if (mem_ack_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_ack_tid_i == TID_W'(i) && state_q[i] == E_SENT) state_d[i] = E_FREE;
         end
      end

      if (st_fire) begin
         if (merge_hit) begin
            for (int b = 0; b < BE_W; b++) begin
               if (st_be_i[b]) data_d[merge_idx][8*b +: 8] = st_data_i[8*b +: 8];
            end
            be_d[merge_idx] = be_q[merge_idx] | st_be_i;
         end else begin
            state_d[wr_ptr_q] = E_PEND;
            addr_d[wr_ptr_q]  = st_word;
            data_d[wr_ptr_q]  = st_data_i;
            be_d[wr_ptr_q]    = st_be_i;
            nc_d[wr_ptr_q]    = st_nc_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
         end
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (state_d[i] != E_FREE) empty_d = 1'b0;
      end
   end

   // Entry state and payload registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= E_FREE;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
            be_q[i]    <= '0;
            nc_q[i]    <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         be_q    <= be_d;
         nc_q    <= nc_d;
      end
   end

   // Allocation/issue pointers, registered empty flag and ack-check arming.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         iss_ptr_q <= '0;
         empty_q   <= 1'b1;
         arm_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         iss_ptr_q <= iss_ptr_d;
         empty_q   <= empty_d;
         arm_q     <= arm_d;
      end
   end

   assign mem_addr_o = addr_q[iss_ptr_q];
   assign mem_data_o = data_q[iss_ptr_q];
   assign mem_be_o   = be_q[iss_ptr_q];
   assign mem_nc_o   = nc_q[iss_ptr_q];
   assign mem_tid_o  = TID_W'(iss_ptr_q);
   assign empty_o    = empty_q;

   // Expose per-entry state for checkers.
   always_comb begin
      dbg_state_o = '0;
      for (int i = 0; i < DEPTH; i++) dbg_state_o[2*i +: 2] = state_q[i];
   end

   // Acks must target an issued, unacknowledged entry.
   ack_to_sent: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (mem_ack_i && arm_q) |-> ack_hits_sent);

endmodule
